hub75_panel_capture: RTL and testbench
======================================

// Module: hub75_panel_capture
// PURPOSE
//  Receive-side model of the HUB75 panel driven by matrix_scan plus the pixel serializer.
//  - Samples the panel shift clock, latch, OE and row address in the clk_in domain.
//  - Deserializes one row of RGB pixel bits and double-buffers it at each latch.
//  - Streams the latched row out as column-addressed pixel words, for scoreboard checks
//    and for on-chip loopback.
// PARAMETERS
//  PANEL_WIDTH     64  columns shifted per row latch
//  COL_ADDR_WIDTH   6  width of out_column; equals clog2(PANEL_WIDTH)
//  ROW_ADDR_WIDTH   4  width of row_address_active and out_row
//  OE_CNT_WIDTH    16  width of oe_cycles
// PORTS
//  clk_in              in   1   system clock; every flop runs on its rising edge
//  reset               in   1   synchronous, active-high
//  clk_pixel           in   1   panel shift clock; a level, sampled on clk_in
//  row_latch           in   1   panel latch; a level, sampled on clk_in
//  output_enable       in   1   high = LEDs lit
//  row_address_active  in   RA  row currently driven to the panel
//  rgb_top             in   3   {r,g,b} for the upper half, valid at the clk_pixel rise
//  rgb_bottom          in   3   {r,g,b} for the lower half
//  out_valid           out  1   out_* word valid
//  out_ready           in   1   sink accepts the word when out_valid && out_ready
//  out_row             out  RA  row address captured at the latch
//  out_column          out  CA  column of this pixel
//  out_rgb             out  6   {rgb_top, rgb_bottom}
//  out_last            out  1   high on column 0, the final word of a row
//  shift_length_error  out  1   sticky: a latch saw a shift count different from PANEL_WIDTH
//  overrun             out  1   sticky: a latch arrived while the previous row was still streaming
//  oe_cycles           out  OC  OE-high clk_in count for the last latched row
// BEHAVIOUR
//  Reset (synchronous):
//   - All outputs clear to 0.
//   - shift_cnt=0, state=IDLE.
//   - Edge-detect history flops (pix_q, lat_q) load 0.
//  Edge detection:
//   - pix_rise = clk_pixel & ~pix_q; lat_rise = row_latch & ~lat_q.
//   - One cycle of registered detection latency.
//  Shift:
//   - On pix_rise with shift_cnt < PANEL_WIDTH: shift_buf[shift_cnt] <= {rgb_top, rgb_bottom}; shift_cnt++.
//   - On pix_rise with shift_cnt == PANEL_WIDTH: shift_cnt saturates, data is dropped, excess flag set.
//   - Shifted pixel k belongs to column PANEL_WIDTH-1-k.
//  Latch (lat_rise):
//   - If shift_cnt != PANEL_WIDTH or excess is set, set shift_length_error.
//   - If state==IDLE:
//     - copy shift_buf to row_buf;
//     - capture row_address_active into out_row;
//     - capture the OE counter into oe_cycles;
//     - go to STREAM with idx=0.
//   - If state==STREAM: set overrun; row_buf and out_row are unchanged; the latch is dropped.
//   - In both cases, shift_cnt, excess and the OE counter clear.
//  Simultaneous pix_rise and lat_rise: the shift applies first, so the latched row includes that pixel.
//  FSM IDLE -> STREAM -> IDLE:
//   - STREAM drives out_valid=1, out_column=PANEL_WIDTH-1-idx, out_rgb=row_buf[idx].
//   - out_last = (idx == PANEL_WIDTH-1).
//   - out_* holds stable while out_valid && !out_ready.
//   - On a handshake, idx++. A handshake with out_last returns to IDLE and drops out_valid the next cycle.
//   - Minimum row time at out_ready=1: PANEL_WIDTH cycles from the cycle after the latch.
//  Sticky flags clear only on reset.
//  Reset mid-stream: out_valid drops the next cycle; the partial row is discarded.
// CONFIGURATION
//  HUB75_CAPTURE_OE_STATS_EN defined:
//   - The OE counter increments each clk_in cycle with output_enable=1.
//   - It saturates at all-ones and clears at each latch; oe_cycles is the value captured at the latch.
//  HUB75_CAPTURE_OE_STATS_EN undefined:
//   - No counter logic; oe_cycles is tied to 0.
// TESTING
//  1. Reset pulse, then idle: all outputs are 0 and out_valid stays 0 for 100 cycles.
//  2. 64 pixel clocks, pixel k = k[5:0], then latch with row_address_active=4'h5, out_ready=1:
//     64 words, out_row=5; first word column 63, rgb 0x00; last word column 0, rgb 0x3F, out_last=1.
//  3. Same row but out_ready toggled 1/0 every cycle: 64 words, each held stable while stalled, order unchanged.
//  4. 63 then 65 pixel clocks before latches: shift_length_error=1 after the first latch and stays 1.
//  5. Second latch 10 cycles after the first while streaming: overrun=1; the first row's 64 words
//     complete unchanged; no second row is emitted.
//  6. With OE stats: output_enable high for 200 cycles between latches -> oe_cycles=200.
//     Without OE stats: oe_cycles=0.

Source files
------------

// File: rtl/hub75_panel_capture_if.sv
// Pixel-word stream from the HUB75 capture block.
// master drives the word and valid; slave returns ready.
interface hub75_panel_capture_if #(
  parameter int COL_ADDR_WIDTH = 6,
  parameter int ROW_ADDR_WIDTH = 4
);
  logic                      out_valid;
  logic                      out_ready;
  logic [ROW_ADDR_WIDTH-1:0] out_row;
  logic [COL_ADDR_WIDTH-1:0] out_column;
  logic [5:0]                out_rgb;
  logic                      out_last;

  modport master (
    output out_valid, out_row, out_column,
    output out_rgb, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_row, out_column,
    input  out_rgb, out_last,
    output out_ready
  );
endinterface

// File: rtl/hub75_panel_capture.sv
// HUB75 receive model: shift, latch, stream one row.
// Optional OE-lit counter: HUB75_CAPTURE_OE_STATS_EN.
module hub75_panel_capture #(
  parameter int PANEL_WIDTH    = 64,
  parameter int COL_ADDR_WIDTH = 6,
  parameter int ROW_ADDR_WIDTH = 4,
  parameter int OE_CNT_WIDTH   = 16
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      clk_pixel,
  input  logic                      row_latch,
  input  logic                      output_enable,
  input  logic [ROW_ADDR_WIDTH-1:0] row_address_active,
  input  logic [2:0]                rgb_top,
  input  logic [2:0]                rgb_bottom,
  hub75_panel_capture_if.master     out_if,
  output logic                      shift_length_error,
  output logic                      overrun,
  output logic [OE_CNT_WIDTH-1:0]   oe_cycles
);
  localparam int CW = COL_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FULL =
    CW'(PANEL_WIDTH);
  localparam logic [COL_ADDR_WIDTH-1:0] LAST =
    COL_ADDR_WIDTH'(PANEL_WIDTH - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                      r_pix_q;
  logic                      r_lat_q;
  logic [CW-1:0]             r_shift_cnt;
  logic                      r_excess;
  logic [5:0]                r_shift_buf [PANEL_WIDTH];
  logic [5:0]                r_row_buf [PANEL_WIDTH];
  logic [COL_ADDR_WIDTH-1:0] r_idx;
  logic [COL_ADDR_WIDTH-1:0] w_idx_nxt;
  logic [ROW_ADDR_WIDTH-1:0] r_out_row;
  logic                      r_sle;
  logic                      r_overrun;

  logic                      w_pix_rise;
  logic                      w_lat_rise;
  logic                      w_pix_wr;
  logic                      w_len_bad;
  logic                      w_stream;
  logic                      w_hs;
  logic [5:0]                w_pixel;
  logic [COL_ADDR_WIDTH-1:0] w_wr_addr;

  assign w_pix_rise = clk_pixel & ~r_pix_q;
  assign w_lat_rise = row_latch & ~r_lat_q;
  assign w_pixel    = {rgb_top, rgb_bottom};
  assign w_pix_wr   = w_pix_rise && (r_shift_cnt < FULL);
  assign w_wr_addr  = r_shift_cnt[COL_ADDR_WIDTH-1:0];
  // A pixel arriving with the latch counts toward its row.
  assign w_len_bad  =
    ((r_shift_cnt + CW'(w_pix_wr)) != FULL) ||
    r_excess || (w_pix_rise && !w_pix_wr);
  assign w_stream   = (r_state == STREAM);
  assign w_hs       = w_stream && out_if.out_ready;

  // Edge-detect history of the panel level signals.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_pix_q <= 1'b0;
      r_lat_q <= 1'b0;
    end else begin
      r_pix_q <= clk_pixel;
      r_lat_q <= row_latch;
    end
  end

  // Shift counter with saturation and excess tracking.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_shift_cnt <= '0;
      r_excess    <= 1'b0;
    end else if (w_lat_rise) begin
      r_shift_cnt <= '0;
      r_excess    <= 1'b0;
    end else if (w_pix_rise) begin
      if (w_pix_wr)
        r_shift_cnt <= r_shift_cnt + CW'(1);
      else
        r_excess <= 1'b1;
    end
  end

  // Shift buffer and double-buffered row copy.
  always_ff @(posedge clk_in) begin
    if (w_pix_wr)
      r_shift_buf[w_wr_addr] <= w_pixel;
    if (w_lat_rise && !w_stream) begin
      for (int i = 0; i < PANEL_WIDTH; i++)
        r_row_buf[i] <= r_shift_buf[i];
      if (w_pix_wr)
        r_row_buf[w_wr_addr] <= w_pixel;
    end
  end

  // Latch bookkeeping: row address and sticky flags.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_out_row <= '0;
      r_sle     <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_lat_rise) begin
      if (w_len_bad)
        r_sle <= 1'b1;
      if (w_stream)
        r_overrun <= 1'b1;
      else
        r_out_row <= row_address_active;
    end
  end

`ifdef HUB75_CAPTURE_OE_STATS_EN
  logic [OE_CNT_WIDTH-1:0] r_oe_cnt;
  logic [OE_CNT_WIDTH-1:0] r_oe_cycles;

  // Lit-cycle counter since the last latch, saturating.
  always_ff @(posedge clk_in) begin
    if (reset)
      r_oe_cnt <= '0;
    else if (w_lat_rise)
      r_oe_cnt <= '0;
    else if (output_enable && !(&r_oe_cnt))
      r_oe_cnt <= r_oe_cnt + OE_CNT_WIDTH'(1);
  end

  // Snapshot of the counter for each accepted row.
  always_ff @(posedge clk_in) begin
    if (reset)
      r_oe_cycles <= '0;
    else if (w_lat_rise && !w_stream)
      r_oe_cycles <= r_oe_cnt;
  end

  assign oe_cycles = r_oe_cycles;
`else
  logic w_unused_oe;
  assign w_unused_oe = output_enable;
  assign oe_cycles   = '0;
`endif

  // Stream FSM state and word index.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next state: start on a latch, leave after the last word.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      IDLE: begin
        if (w_lat_rise) begin
          w_state_nxt = STREAM;
          w_idx_nxt   = '0;
        end
      end
      STREAM: begin
        if (w_hs) begin
          w_idx_nxt = r_idx + COL_ADDR_WIDTH'(1);
          if (r_idx == LAST)
            w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign out_if.out_valid  = w_stream;
  assign out_if.out_row    = r_out_row;
  assign out_if.out_column =
    w_stream ? (LAST - r_idx) : '0;
  assign out_if.out_rgb    =
    w_stream ? r_row_buf[r_idx] : '0;
  assign out_if.out_last   =
    w_stream && (r_idx == LAST);

  assign shift_length_error = r_sle;
  assign overrun            = r_overrun;
endmodule

// File: tb/tb_hub75_panel_capture.sv
// Randomized bench for hub75_panel_capture.
// Reference model: pixel array + expected word queue.
module tb_hub75_panel_capture;
  localparam int W = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_pixel;
  logic        row_latch;
  logic        output_enable;
  logic [3:0]  row_address_active;
  logic [2:0]  rgb_top;
  logic [2:0]  rgb_bottom;
  logic        shift_length_error;
  logic        overrun;
  logic [15:0] oe_cycles;

  hub75_panel_capture_if #(
    .COL_ADDR_WIDTH(6),
    .ROW_ADDR_WIDTH(4)
  ) u_if ();

  hub75_panel_capture u_dut (
    .clk_in             (clk),
    .reset              (reset),
    .clk_pixel          (clk_pixel),
    .row_latch          (row_latch),
    .output_enable      (output_enable),
    .row_address_active (row_address_active),
    .rgb_top            (rgb_top),
    .rgb_bottom         (rgb_bottom),
    .out_if             (u_if.master),
    .shift_length_error (shift_length_error),
    .overrun            (overrun),
    .oe_cycles          (oe_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int col;
    int rgb;
    int row;
    int last;
  } word_t;

  word_t exp_q[$];
  int    m_sb [W];
  int    m_cnt;
  bit    m_exc;
  bit    m_sle;
  bit    m_ovr;
  int    m_oe;
  int    m_oe_cap;
  int    rdy_mode;
  int    n_chk;
  int    n_pass;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, obs, exp);
  endtask

  // Model: a pixel lands at the next free slot.
  task automatic px(input logic [5:0] p);
    rgb_top    = p[5:3];
    rgb_bottom = p[2:0];
    clk_pixel  = 1'b1;
    if (m_cnt < W) begin
      m_sb[m_cnt] = int'(p);
      m_cnt++;
    end else m_exc = 1'b1;
    repeat (2) @(posedge clk);
    #1 clk_pixel = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Model: idle latch queues a row, busy latch overruns.
  task automatic latch(input logic [3:0] row);
    if (m_cnt != W || m_exc) m_sle = 1'b1;
    if (exp_q.size() == 0) begin
      for (int i = 0; i < W; i++)
        exp_q.push_back('{W - 1 - i, m_sb[i],
                          int'(row), int'(i == W - 1)});
      m_oe_cap = m_oe;
    end else m_ovr = 1'b1;
    m_cnt = 0;
    m_exc = 1'b0;
    m_oe  = 0;
    row_address_active = row;
    row_latch = 1'b1;
    repeat (2) @(posedge clk);
    #1 row_latch = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag);
    int oe_exp;
`ifdef HUB75_CAPTURE_OE_STATS_EN
    oe_exp = m_oe_cap;
`else
    oe_exp = 0;
`endif
    chk({tag, "_sle"}, shift_length_error, m_sle);
    chk({tag, "_ovr"}, overrun, m_ovr);
    chk({tag, "_oe"}, oe_cycles, oe_exp);
  endtask

  task automatic rand_row(input int n);
    for (int k = 0; k < n; k++)
      px(6'($urandom_range(0, 63)));
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: u_if.out_ready = 1'b1;
      1: u_if.out_ready = ~u_if.out_ready;
      default: u_if.out_ready = 1'($urandom);
    endcase
  end

  // Every valid word must match the queue head,
  // and it stays there until a handshake.
  always @(negedge clk) begin
    if (!reset && u_if.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        chk("col", u_if.out_column, exp_q[0].col);
        chk("rgb", u_if.out_rgb, exp_q[0].rgb);
        chk("row", u_if.out_row, exp_q[0].row);
        chk("last", u_if.out_last, exp_q[0].last);
        if (u_if.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rdy_mode = 0;
    m_cnt = 0;
    m_exc = 0;
    m_sle = 0;
    m_ovr = 0;
    m_oe = 0;
    m_oe_cap = 0;
    for (int i = 0; i < W; i++) m_sb[i] = 0;
    reset = 1'b1;
    clk_pixel = 1'b0;
    row_latch = 1'b0;
    output_enable = 1'b0;
    row_address_active = '0;
    rgb_top = '0;
    rgb_bottom = '0;
    u_if.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_valid", u_if.out_valid, 0);
    chk("rst_col", u_if.out_column, 0);
    chk("rst_rgb", u_if.out_rgb, 0);
    chk("rst_row", u_if.out_row, 0);
    chk("rst_last", u_if.out_last, 0);
    chk_flags("rst");
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1 chk("idle_valid", u_if.out_valid, 0);
    end

    for (int k = 0; k < W; k++) px(6'(k));
    latch(4'h5);
    chk_flags("row_inc");
    drain(200);

    rdy_mode = 1;
    for (int k = 0; k < W; k++) px(6'(k));
    latch(4'h5);
    drain(400);
    chk_flags("toggle");

    rdy_mode = 2;
    rand_row(63);
    latch(4'(($urandom)));
    chk_flags("short");
    drain(1000);
    rand_row(65);
    latch(4'(($urandom)));
    chk_flags("long");
    drain(1000);

    rdy_mode = 0;
    rand_row(W);
    latch(4'h9);
    repeat (6) @(posedge clk);
    #1;
    latch(4'h3);
    chk_flags("overrun");
    drain(200);

    rand_row(W);
    latch(4'h2);
    output_enable = 1'b1;
    m_oe += 200;
    repeat (200) @(posedge clk);
    #1 output_enable = 1'b0;
    drain(200);
    rdy_mode = 2;
    rand_row(W);
    latch(4'hc);
    chk_flags("oe");
    drain(1000);

    rdy_mode = 0;
    rand_row(W);
    latch(4'h7);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    m_cnt = 0;
    m_exc = 0;
    m_sle = 0;
    m_ovr = 0;
    m_oe = 0;
    m_oe_cap = 0;
    reset = 1'b0;
    chk("midrst_valid", u_if.out_valid, 0);
    chk_flags("midrst");
    repeat (20) @(posedge clk);
    #1 chk("post_rst_valid", u_if.out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
